hs_byte_packer: RTL and testbench
=================================

HS_BYTE_PACKER -- requirements
Module: hs_byte_packer

Interface
REQ-001 Parameter WORD_WIDTH, default 8, SHALL set the width of one upstream beat (lane) in bits.
REQ-002 Parameter LANES, default 4, SHALL set the number of lanes per output word; legal values are powers of two from 2 to 8.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 up_valid  input  1  SHALL flag a valid upstream beat.
REQ-006 up_data  input  WORD_WIDTH  SHALL carry the upstream beat payload.
REQ-007 up_last  input  1  SHALL mark the beat that closes the current packet.
REQ-008 up_ready  output  1  SHALL flag that the packer accepts a beat this cycle.
REQ-009 down_valid  output  1  SHALL flag a valid packed word.
REQ-010 down_data  output  WORD_WIDTH*LANES  SHALL carry the packed word, with lane 0 in the LSBs.
REQ-011 down_keep  output  LANES  SHALL be a per-lane valid mask.
REQ-012 down_last  output  1  SHALL flag that the word was closed by up_last.
REQ-013 down_ready  input  1  SHALL flag that the downstream accepts the word.
REQ-014 words_sent  output  16  SHALL hold the running count of accepted output words.

Function
REQ-015 An upstream transfer SHALL occur when up_valid && up_ready; a downstream transfer SHALL occur when down_valid && down_ready.
REQ-016 up_ready SHALL equal rst_n && (!down_valid || down_ready); this is a combinational path from down_ready and is legal because the upstream register slice breaks it.
REQ-017 Lane pointer cnt (0..LANES-1) SHALL be at 0 in state EMPTY and at 1..LANES-1 in state FILL.
REQ-018 Each accepted beat SHALL be written to lane cnt of the accumulator, and its keep bit SHALL be set.
REQ-019 A beat SHALL close the word if cnt==LANES-1 or up_last==1.
REQ-020 On a closing beat, the accumulator plus that beat SHALL be loaded into the output register in the same edge: down_valid=1, down_keep set, unused lanes' data zero, down_last=up_last.
REQ-021 After a closing beat, cnt SHALL return to 0 (state EMPTY) and the accumulator and keep SHALL clear.
REQ-022 A non-closing beat SHALL increment cnt; the FSM SHALL move EMPTY->FILL on it and stay in FILL until a closing beat.
REQ-023 Latency SHALL be 1 cycle: down_valid rises on the edge that accepts the closing beat.
REQ-024 While down_valid && !down_ready, down_data, down_keep and down_last SHALL hold stable and up_ready SHALL be 0.
REQ-025 On a downstream transfer without a simultaneous closing beat, down_valid SHALL clear on the same edge.
REQ-026 On a downstream transfer with a simultaneous closing beat, the new word SHALL replace the old one with down_valid staying 1 (back-to-back, no bubble).
REQ-027 words_sent SHALL increment by 1 per downstream transfer and wrap from 0xFFFF to 0x0000.
REQ-028 up_last on the first beat SHALL produce a one-lane word with down_keep = 1 (lane 0 only).

Reset
REQ-029 While rst_n==0 at a rising edge, the block SHALL set down_valid=0, down_data=0, down_keep=0, down_last=0, words_sent=0, cnt=0, accumulator=0, and state=EMPTY.
REQ-030 While rst_n==0, up_ready SHALL be 0.
REQ-031 A reset mid-packet SHALL discard any partial word and any pending output word, and the first beat after reset SHALL land in lane 0.

Structure
REQ-032 Shared package hs_pkg SHALL hold the default WORD_WIDTH and LANES constants and the packer state typedef (EMPTY, FILL).
REQ-033 The block SHALL be a single module with no sub-module.
REQ-034 Parameter checks (LANES a power of two within range) SHALL be elaboration-time assertions.

Verification
REQ-035 Scenario: beats 0x11,0x22,0x33,0x44 with down_ready=1 -> down_data=0x44332211, down_keep=4'hF, down_last=0, down_valid high 1 cycle after the 4th accept.
REQ-036 Scenario: beats 0xAA then 0xBB with up_last=1 -> down_data=0x0000BBAA, down_keep=4'b0011, down_last=1.
REQ-037 Scenario: word pending with down_ready=0 for 5 cycles -> up_ready=0 and outputs stable for all 5 cycles; when down_ready=1, the word transfers and words_sent increments by 1.
REQ-038 Scenario: continuous up_valid, down_ready=1, 8 beats -> two words on consecutive closing edges with no bubble, and words_sent=2.
REQ-039 Scenario: 2 beats accepted, then rst_n=0 for 1 cycle, then 0x01,0x02,0x03,0x04 -> single word 0x04030201 with keep 4'hF and no trace of the discarded bytes.
REQ-040 Scenario: words_sent preloaded to 0xFFFF via 65535 words, then one more word -> words_sent=0x0000.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared constants and state type for the byte packer.
// Lane-count legality helper is used for elaboration-time parameter checks.
package hs_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 8;
    localparam int unsigned DEF_LANES      = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } state_t;

    // Legal lane counts are powers of two from 2 to 8.
    function automatic bit lanes_legal(input int unsigned n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/hs_byte_packer.sv
// Packs narrow upstream beats into LANES-wide words with a keep mask.
// A packet's last beat closes a partial word; output is a single register stage.
module hs_byte_packer
    import hs_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned LANES      = DEF_LANES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          up_valid,
    input  logic [WORD_WIDTH-1:0]         up_data,
    input  logic                          up_last,
    output logic                          up_ready,
    output logic                          down_valid,
    output logic [WORD_WIDTH*LANES-1:0]   down_data,
    output logic [LANES-1:0]              down_keep,
    output logic                          down_last,
    input  logic                          down_ready,
    output logic [15:0]                   words_sent
);

    localparam int unsigned DW = WORD_WIDTH * LANES;
    localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;

    if (!lanes_legal(LANES)) begin : g_lanes_check
        $error("hs_byte_packer: LANES must be 2, 4 or 8");
    end
    if (WORD_WIDTH < 1) begin : g_width_check
        $error("hs_byte_packer: WORD_WIDTH must be at least 1");
    end

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      acc_data;
    logic [LANES-1:0]   acc_keep;

    logic               up_fire;
    logic               down_fire;
    logic               closing;
    logic [DW-1:0]      merged_data;
    logic [LANES-1:0]   merged_keep;

    // Ready only when the output register is free or draining this cycle.
    assign up_ready  = rst_n && (!down_valid || down_ready);
    assign up_fire   = up_valid && up_ready;
    assign down_fire = down_valid && down_ready;
    assign closing   = up_fire && ((cnt == CW'(LANES - 1)) || up_last);

    // Accumulator with the incoming beat dropped into lane cnt.
    always_comb begin
        merged_data = (state == FILL) ? acc_data : '0;
        merged_keep = (state == FILL) ? acc_keep : '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (cnt == CW'(i)) begin
                merged_data[i*WORD_WIDTH +: WORD_WIDTH] = up_data;
                merged_keep[i]                          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            cnt        <= '0;
            acc_data   <= '0;
            acc_keep   <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_keep  <= '0;
            down_last  <= 1'b0;
            words_sent <= '0;
        end else begin
            if (down_fire) begin
                words_sent <= words_sent + 16'd1;
            end

            if (closing) begin
                // New word replaces any word leaving this edge: no bubble.
                down_valid <= 1'b1;
                down_data  <= merged_data;
                down_keep  <= merged_keep;
                down_last  <= up_last;
                state      <= EMPTY;
                cnt        <= '0;
                acc_data   <= '0;
                acc_keep   <= '0;
            end else begin
                if (down_fire) begin
                    down_valid <= 1'b0;
                end
                if (up_fire) begin
                    state    <= FILL;
                    cnt      <= cnt + CW'(1);
                    acc_data <= merged_data;
                    acc_keep <= merged_keep;
                end
            end
        end
    end

endmodule

// File: tb/tb_hs_byte_packer.sv
// Self-checking bench for hs_byte_packer: table-driven packets through a
// scoreboard, plus hand sequences for backpressure, reset and counter wrap.
module tb_hs_byte_packer;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned DW = W * L;

    logic          clk;
    logic          rst_n;
    logic          up_valid;
    logic [W-1:0]  up_data;
    logic          up_last;
    logic          up_ready;
    logic          down_valid;
    logic [DW-1:0] down_data;
    logic [L-1:0]  down_keep;
    logic          down_last;
    logic          down_ready;
    logic [15:0]   words_sent;

    hs_byte_packer #(.WORD_WIDTH(W), .LANES(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_last    (up_last),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_keep  (down_keep),
        .down_last  (down_last),
        .down_ready (down_ready),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [L-1:0]  keep;
        logic          last;
    } word_t;

    typedef struct {
        int unsigned   nb;
        logic [DW-1:0] beats;
        logic          last;
        logic [DW-1:0] exp_data;
        logic [L-1:0]  exp_keep;
        logic          exp_last;
    } vec_t;

    word_t       sb[$];
    int          checks;
    int          errors;
    logic [15:0] exp_ws;
    bit          mon_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Sampled on the falling edge; a transfer seen here happens at the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("words_sent_track", 64'(words_sent), 64'(exp_ws));
            if (down_valid && down_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", down_data);
                end else begin
                    word_t e;
                    e = sb.pop_front();
                    check("word_data", 64'(down_data), 64'(e.data));
                    check("word_keep", 64'(down_keep), 64'(e.keep));
                    check("word_last", 64'(down_last), 64'(e.last));
                end
                exp_ws = exp_ws + 16'd1;
            end
        end
    end

    task automatic do_reset();
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        up_valid = 1'b0;
        up_last  = 1'b0;
        up_data  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_ws = '0;
        mon_en = 1'b1;
    endtask

    // Presents one beat and returns just after the edge that accepts it; leaves up_valid high.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int t;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        @(negedge clk);
        t = 0;
        while (!up_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!up_ready) begin
            checks++;
            errors++;
            $display("FAIL up_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [L-1:0] k, input logic l);
        word_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        sb.push_back(e);
    endtask

    vec_t vecs[5];

    initial begin
        logic [DW-1:0] held;
        checks     = 0;
        errors     = 0;
        exp_ws     = '0;
        mon_en     = 1'b0;
        down_ready = 1'b1;

        vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1'b0};
        vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3, 1'b1};
        vecs[2] = '{1, 32'h000000C3, 1'b1, 32'h000000C3, 4'h1, 1'b1};
        vecs[3] = '{3, 32'h00332211, 1'b1, 32'h00332211, 4'h7, 1'b1};
        vecs[4] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1};

        // Reset state, including the combinational up_ready under reset.
        rst_n    = 1'b0;
        up_valid = 1'b1;
        up_last  = 1'b0;
        up_data  = 8'h99;
        @(posedge clk);
        #1;
        check("rst_up_ready", 64'(up_ready), 64'd0);
        check("rst_down_valid", 64'(down_valid), 64'd0);
        check("rst_down_data", 64'(down_data), 64'd0);
        check("rst_down_keep", 64'(down_keep), 64'd0);
        check("rst_down_last", 64'(down_last), 64'd0);
        check("rst_words_sent", 64'(words_sent), 64'd0);
        do_reset();

        // Table packets; down_valid must be high right after the closing accept.
        for (int v = 0; v < 5; v++) begin
            push_word(vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last);
            for (int b = 0; b < int'(vecs[v].nb); b++) begin
                logic [DW-1:0] bw;
                bw = vecs[v].beats >> (b * W);
                send_beat(bw[W-1:0], (b == int'(vecs[v].nb) - 1) ? vecs[v].last : 1'b0);
            end
            check("latency_valid", 64'(down_valid), 64'd1);
            up_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end

        // Backpressure: word pending for 5 cycles must hold and block upstream.
        down_ready = 1'b0;
        push_word(32'h0000BBAA, 4'h3, 1'b1);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        up_data = 8'h77;
        up_last = 1'b1;
        held = down_data;
        check("bp_held_data", 64'(held), 64'h0000BBAA);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_up_ready", 64'(up_ready), 64'd0);
            check("bp_stable_data", 64'(down_data), 64'(held));
            check("bp_stable_keep", 64'(down_keep), 64'h3);
        end
        up_valid = 1'b0;
        check("bp_ws_before", 64'(words_sent), 64'd5);
        down_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ws_after", 64'(words_sent), 64'd6);
        check("bp_valid_cleared", 64'(down_valid), 64'd0);

        // Continuous 8 beats: two full words, counter reaches 2.
        do_reset();
        push_word(32'h44332211, 4'hF, 1'b0);
        push_word(32'h88776655, 4'hF, 1'b0);
        for (int b = 1; b <= 8; b++) begin
            send_beat(W'(b * 8'h11), 1'b0);
            if (b == 4 || b == 8) check("b2b_valid", 64'(down_valid), 64'd1);
        end
        up_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ws", 64'(words_sent), 64'd2);

        // Single-lane words every cycle: down_valid never drops between them.
        push_word(32'h000000A1, 4'h1, 1'b1);
        push_word(32'h000000A2, 4'h1, 1'b1);
        push_word(32'h000000A3, 4'h1, 1'b1);
        send_beat(8'hA1, 1'b1);
        send_beat(8'hA2, 1'b1);
        check("nobubble_valid", 64'(down_valid), 64'd1);
        send_beat(8'hA3, 1'b1);
        check("nobubble_data", 64'(down_data), 64'h000000A3);
        up_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Mid-packet reset discards the partial word.
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        do_reset();
        push_word(32'h04030201, 4'hF, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        check("rst_mid_data", 64'(down_data), 64'h04030201);
        check("rst_mid_keep", 64'(down_keep), 64'hF);
        up_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);

        // Counter wrap: 65535 one-lane words, then one more.
        do_reset();
        mon_en     = 1'b0;
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_last    = 1'b1;
        up_data    = 8'h5A;
        repeat (65535) @(posedge clk);
        #1;
        up_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_ffff", 64'(words_sent), 64'hFFFF);
        send_beat(8'h5B, 1'b1);
        up_valid = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_zero", 64'(words_sent), 64'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
